// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin burst arbiter driving the shared VGA adapter write port.
// Defining VGA_ARB_TIMEOUT_EN caps each grant at MAX_BURST pixels and flags forced releases.
module vga_plot_arbiter #(
   parameter int N_REQ     = 3,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int C_W       = 3,
   parameter int MAX_BURST = 250
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     last,
   input  logic [N_REQ-1:0]     plot_in,
   input  logic [N_REQ*X_W-1:0] x_in,
   input  logic [N_REQ*Y_W-1:0] y_in,
   input  logic [N_REQ*C_W-1:0] colour_in,
   output logic [N_REQ-1:0]     grant,
   output logic [X_W-1:0]       x_out,
   output logic [Y_W-1:0]       y_out,
   output logic [C_W-1:0]       colour_out,
   output logic                 plot_out,
   output logic                 busy,
   output logic                 timeout_err
);
   localparam int PW = $clog2(N_REQ);
   typedef enum logic {IDLE, BURST} state_e;
   state_e           state_q;
   logic [N_REQ-1:0] grant_q;
   logic [PW-1:0]    rr_ptr_q, win_d, cand;
   logic             found;
   logic             plot_q;
   logic [X_W-1:0]   x_q;
   logic [Y_W-1:0]   y_q;
   logic [C_W-1:0]   colour_q;
   logic [X_W-1:0]   xs [N_REQ];
   logic [Y_W-1:0]   ys [N_REQ];
   logic [C_W-1:0]   cs [N_REQ];
   logic             pg, lg, rg, px_end, tmo, end_d;
   for (genvar i = 0; i < N_REQ; i++) begin : g_sl
      assign xs[i] = x_in[i*X_W +: X_W];
      assign ys[i] = y_in[i*Y_W +: Y_W];
      assign cs[i] = colour_in[i*C_W +: C_W];
   end
   // in BURST the round-robin pointer doubles as the granted index
   assign pg     = plot_in[rr_ptr_q];
   assign lg     = last[rr_ptr_q];
   assign rg     = req[rr_ptr_q];
   assign px_end = pg & lg;
   assign end_d  = px_end | ~rg | tmo;
   always_comb begin
      win_d = rr_ptr_q;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = PW'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win_d = cand;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= PW'(N_REQ - 1);
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else if (state_q == IDLE) begin
         plot_q <= 1'b0;
         if (|req) begin
            state_q  <= BURST;
            grant_q  <= N_REQ'(1) << win_d;
            rr_ptr_q <= win_d;
         end
      end else begin
         x_q      <= xs[rr_ptr_q];
         y_q      <= ys[rr_ptr_q];
         colour_q <= cs[rr_ptr_q];
         plot_q   <= pg;
         if (end_d) begin
            state_q <= IDLE;
            grant_q <= '0;
         end
      end
   end
`ifdef VGA_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_BURST + 1);
   logic [CW-1:0] burst_cnt_q;
   logic          timeout_err_q;
   assign tmo = state_q == BURST && pg && burst_cnt_q == CW'(MAX_BURST - 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         burst_cnt_q <= state_q == IDLE ? '0 :
                        burst_cnt_q + CW'(pg && burst_cnt_q != CW'(MAX_BURST));
         if (tmo && !px_end) timeout_err_q <= 1'b1;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   logic unused_max_burst;
   assign unused_max_burst = ^MAX_BURST;
   assign tmo              = 1'b0;
   assign timeout_err      = 1'b0;
`endif
   assign grant      = grant_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = colour_q;
   assign plot_out   = plot_q;
   assign busy       = state_q == BURST;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed bench for vga_plot_arbiter (expects 250-pixel cap when VGA_ARB_TIMEOUT_EN is defined).
`timescale 1ns/1ps
module tb_vga_plot_arbiter;
   localparam int N = 3, X_W = 8, Y_W = 7, C_W = 3;
   logic           clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0]   req = '0, last = '0, plot_in = '0;
   logic [N*X_W-1:0] x_in = '0;
   logic [N*Y_W-1:0] y_in = '0;
   logic [N*C_W-1:0] colour_in = '0;
   logic [N-1:0]   grant;
   logic [X_W-1:0] x_out;
   logic [Y_W-1:0] y_out;
   logic [C_W-1:0] colour_out;
   logic           plot_out, busy, timeout_err;
   int checks = 0, errors = 0;
   logic [17:0] exp_a [512];
   int wp = 0, rp = 0;

   vga_plot_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .last(last), .plot_in(plot_in),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot_out(plot_out),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (plot_out) begin
         chk("pix_avail", 32'(rp < wp), 1);
         chk("pix", {x_out, y_out, colour_out}, exp_a[rp]);
         rp <= rp + 1;
      end
   end

   task automatic drive_px(input int i, input int p, input bit l, input bit push);
      plot_in[i] = 1'b1;
      last[i]    = l;
      x_in[i*X_W +: X_W]      = X_W'(i*64 + p);
      y_in[i*Y_W +: Y_W]      = Y_W'(p*3 + i);
      colour_in[i*C_W +: C_W] = C_W'(p + i);
      if (push) begin
         exp_a[wp] = {X_W'(i*64 + p), Y_W'(p*3 + i), C_W'(p + i)};
         wp++;
      end
   endtask

   task automatic send(input int i, input int n, input bit use_last, output int sent);
      int t = 0;
      sent = 0;
      while (!grant[i] && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("grant_wait", 32'(grant[i]), 1);
      while (sent < n && grant[i]) begin
         drive_px(i, sent, use_last && sent == n - 1, 1'b1);
         sent++;
         @(negedge clk);
      end
      plot_in[i] = 1'b0;
      last[i]    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, base;
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_plot", 32'(plot_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pix", {x_out, y_out, colour_out}, 0);
      chk("rst_terr", 32'(timeout_err), 0);
      reset_n = 1'b1;
      @(negedge clk);
      // single 25-pixel burst from requester 0
      base = rp;
      req = 3'b001;
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      send(0, 25, 1'b1, s);
      chk("t1_sent", s, 25);
      chk("t1_release", 32'(grant), 0);
      req = 3'b000;
      @(negedge clk);
      chk("t1_pulses", rp - base, 25);
      chk("t1_busy_end", 32'(busy), 0);
      // round robin after a fresh reset
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      base = rp;
      req = 3'b111;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         chk("rr_order", 32'(grant), 32'(1 << (k % 3)));
         send(k % 3, 4, 1'b1, s);
         chk("rr_len", s, 4);
         chk("rr_dead", 32'(grant), 0);
         if (k == 5) req = 3'b000;
         @(negedge clk);
      end
      chk("rr_pulses", rp - base, 24);
      // non-granted requesters toggling must never leak through
      base = rp;
      req = 3'b010;
      @(negedge clk);
      chk("t3_grant", 32'(grant), 32'h2);
      for (int c = 0; c < 8; c++) begin
         drive_px(1, c, c == 7, 1'b1);
         plot_in[0] = c[0];
         plot_in[2] = c[0];
         last[0]    = c[0];
         last[2]    = c[0];
         x_in[0 +: X_W]     = X_W'(8'hE0 + c);
         x_in[2*X_W +: X_W] = X_W'(8'hF0 + c);
         @(negedge clk);
      end
      chk("t3_release", 32'(grant), 0);
      req = 3'b000; plot_in = '0; last = '0;
      @(negedge clk);
      chk("t3_pulses", rp - base, 8);
      // requester 2 drops req mid-burst
      base = rp;
      req = 3'b100;
      @(negedge clk);
      send(2, 10, 1'b0, s);
      chk("t4_sent", s, 10);
      chk("t4_held", 32'(grant), 32'h4);
      req = 3'b000;
      @(negedge clk);
      chk("t4_release", 32'(grant), 0);
      chk("t4_terr", 32'(timeout_err), 0);
      chk("t4_pulses", rp - base, 10);
      // 300-pixel stream with no last
      base = rp;
      req = 3'b010;
      @(negedge clk);
      send(1, 300, 1'b0, s);
      req = 3'b000;
      @(negedge clk);
      chk("t5_release", 32'(grant), 0);
`ifdef VGA_ARB_TIMEOUT_EN
      chk("t5_sent", s, 250);
      chk("t5_pulses", rp - base, 250);
      chk("t5_terr", 32'(timeout_err), 1);
      repeat (3) @(negedge clk);
      chk("t5_terr_sticky", 32'(timeout_err), 1);
`else
      chk("t5_sent", s, 300);
      chk("t5_pulses", rp - base, 300);
      chk("t5_terr", 32'(timeout_err), 0);
`endif
      // asynchronous reset in the middle of a burst
      req = 3'b001;
      @(negedge clk);
      chk("t6_grant", 32'(grant), 32'h1);
      drive_px(0, 0, 1'b0, 1'b1);
      @(negedge clk);
      drive_px(0, 1, 1'b0, 1'b0);
      #2;
      chk("t6_plot_pre", 32'(plot_out), 1);
      reset_n = 1'b0;
      #1;
      chk("t6_grant_rst", 32'(grant), 0);
      chk("t6_plot_rst", 32'(plot_out), 0);
      chk("t6_busy_rst", 32'(busy), 0);
      chk("t6_x_rst", 32'(x_out), 0);
      chk("t6_terr_rst", 32'(timeout_err), 0);
      plot_in = '0; last = '0; req = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      req = 3'b110;
      @(negedge clk);
      chk("t6_first", 32'(grant), 32'h2);
      req = 3'b000;
      repeat (2) @(negedge clk);
      chk("t6_idle", 32'(grant), 0);
      chk("drained", rp, wp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter write port (x, y, colour, plot) among several pixel-drawing requesters: player sprite, enemy field and score/overlay drawers. Requesters ask for the port with `req`, stream pixels while granted, and release it with `last` on their final pixel. The arbiter grants the port round-robin, holds the grant for a whole burst, and registers the muxed pixel stream toward the adapter. It sits between the drawing datapaths and the VGA adapter, alongside the game FSM that raises the requests.

## Interface
- `N_REQ`, 3: number of requesters (2–8).
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `C_W`, 3: colour width.
- `MAX_BURST`, 250: pixel cap per grant (only with timeout feature).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester port request, level.
- `last`  in  N_REQ  marks the final pixel of a burst; qualified by `plot_in`.
- `plot_in`  in  N_REQ  per-requester pixel-valid.
- `x_in`  in  N_REQ*X_W  flattened; requester i at [i*X_W +: X_W].
- `y_in`  in  N_REQ*Y_W  flattened, same packing.
- `colour_in`  in  N_REQ*C_W  flattened, same packing.
- `grant`  out  N_REQ  one-hot or zero; registered.
- `x_out`, `y_out`, `colour_out`  out  X_W / Y_W / C_W  to adapter; registered.
- `plot_out`  out  1  to adapter; registered.
- `busy`  out  1  high in BURST state.
- `timeout_err`  out  1  sticky; set on forced release.

## Operation
- States: IDLE, BURST.
- IDLE: `grant` = 0. If any `req` bit is high, pick the first requesting index after `rr_ptr`, searching upward with wrap. Register the winner's one-hot `grant`, set `rr_ptr` to the winner, clear `burst_cnt`, and go to BURST.
- BURST, granted index g, each cycle:
  - `x_out`/`y_out`/`colour_out` <= the g slice.
  - `plot_out` <= `plot_in[g]`.
  - Non-granted `plot_in`/`last` are ignored.
  - `burst_cnt` increments on each `plot_in[g]`.
- Burst end (go to IDLE, `grant` <= 0) when any of:
  - `plot_in[g] & last[g]`: that pixel is still forwarded.
  - `req[g]` low: the pixel presented that cycle is still forwarded if `plot_in[g]`.
  - Timeout, described under Configuration.
- `last[g]` without `plot_in[g]` is ignored.
- `req[g]` falling and `last` in the same cycle: single normal end, no error.
- Outside BURST: `plot_out` = 0. The coordinate and colour outputs hold their last values.
- Reset, asynchronous and taking effect immediately, including mid-burst:
  - state = IDLE.
  - `grant`, `plot_out`, `x_out`, `y_out`, `colour_out`, `busy`, `timeout_err`, `burst_cnt` = 0.
  - `rr_ptr` = N_REQ-1, so requester 0 wins first.
- `burst_cnt` width is clog2(MAX_BURST+1). It saturates and never wraps.

## Timing
- `req` seen high in IDLE at edge k → `grant`/`busy` high after edge k.
- Pixel latency: `plot_in` at edge k → `plot_out`/`x_out`/`y_out`/`colour_out` after edge k.
- End detected at edge k → `grant` low after k. Earliest next grant is after edge k+1, giving one dead cycle between bursts.
- Steady throughput: 1 pixel/cycle.
- Requesters must treat `grant` as the only permission to advance their pixel counters.

## Configuration
- `VGA_ARB_TIMEOUT_EN` defined:
  - When `burst_cnt` reaches MAX_BURST with no `last`, the grant is forcibly released. The MAX_BURST-th pixel is forwarded.
  - `timeout_err` is set and stays set until reset.
  - `rr_ptr` advances as for a normal end.
- Not defined: no cap, no burst counter logic, `timeout_err` tied 0.

## Test plan
- Reset, then `req`=3'b001; requester 0 sends 25 pixels with `last` on the 25th → `grant`=001 one cycle after `req`. Exactly 25 `plot_out` pulses with matching x/y/colour, one cycle delayed. `grant`=000 one cycle after `last`.
- `req`=3'b111 held, each burst 4 pixels → grant order 0,1,2,0,1,2, with exactly one idle cycle between bursts.
- Requester 1 granted, `plot_in[0]`/`plot_in[2]` toggling → never appear on `plot_out`.
- Requester 2 drops `req` mid-burst after 10 pixels → 10 `plot_out` pulses, grant released the next cycle, `timeout_err`=0.
- `VGA_ARB_TIMEOUT_EN`, MAX_BURST=250, requester 1 streams 300 pixels without `last` → exactly 250 pixels forwarded, grant released, `timeout_err`=1 until reset. Without the macro → all 300 pixels forwarded, `timeout_err`=0.
- `reset_n` low mid-burst → `grant`/`plot_out` go to 0 immediately. After release with `req`=3'b110, requester 1 wins first.
